// File: rtl/strobe_serial_tx_pkg.sv
// rtl/strobe_serial_tx_pkg.sv - shared types and helpers for the strobe-clocked serial transmitter
package strobe_serial_tx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam logic IDLE_LEVEL = 1'b0;

   function automatic int frame_bits(input int data_w, input bit parity);
      return parity ? data_w + 1 : data_w;
   endfunction

endpackage

// File: rtl/strobe_serial_tx_if.sv
// rtl/strobe_serial_tx_if.sv - word handshake and serial link signals of strobe_serial_tx
interface strobe_serial_tx_if #(
   parameter int DATA_W = 8
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              sdata;
   logic              sstrobe;
   logic              busy;
   logic              done;

   modport master (
      output in_valid, in_data,
      input  in_ready, sdata, sstrobe, busy, done
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, sdata, sstrobe, busy, done
   );
endinterface

// File: rtl/strobe_phase_div.sv
// rtl/strobe_phase_div.sv - DIV-cycle phase counter; phase_end marks the last cycle of each phase
module strobe_phase_div #(
   parameter int DIV = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   output logic phase_end
);
   localparam int CW = $clog2(DIV + 1);

   logic [CW-1:0] cnt;

   // Free-running between frames; start realigns it to the accept edge.
   always_ff @(posedge clk) begin
      if (reset || start || phase_end) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign phase_end = (cnt == CW'(DIV - 1));
endmodule

// File: rtl/strobe_serial_tx.sv
// rtl/strobe_serial_tx.sv - LSB-first serial transmitter with mid-bit capture strobe; STROBE_SERIAL_TX_PARITY_EN appends even parity
module strobe_serial_tx
   import strobe_serial_tx_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DIV    = 2
) (
   input  logic clk,
   input  logic reset,
   strobe_serial_tx_if.slave bus
);
`ifdef STROBE_SERIAL_TX_PARITY_EN
   localparam int NBITS = frame_bits(DATA_W, 1'b1);
`else
   localparam int NBITS = frame_bits(DATA_W, 1'b0);
`endif
   localparam int BW = $clog2(NBITS + 1);

   state_t           state, state_nxt;
   logic [NBITS-1:0] shreg, shreg_nxt, load_word;
   logic [BW-1:0]    bitcnt, bitcnt_nxt;
   logic             sdata_q, sdata_nxt;
   logic             sstrobe_q, sstrobe_nxt;
   logic             done_q, done_nxt;
   logic             accept, phase_end, last_bit;

   assign bus.in_ready = (state == IDLE) && !reset;
   assign accept       = bus.in_valid && bus.in_ready;
   assign last_bit     = (bitcnt == BW'(NBITS - 1));

`ifdef STROBE_SERIAL_TX_PARITY_EN
   // Parity rides in the top bit of the shift register so it leaves last.
   assign load_word = {^bus.in_data, bus.in_data};
`else
   assign load_word = bus.in_data;
`endif

   strobe_phase_div #(.DIV(DIV)) u_phase_div (
      .clk       (clk),
      .reset     (reset),
      .start     (accept),
      .phase_end (phase_end)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         shreg     <= '0;
         bitcnt    <= '0;
         sdata_q   <= IDLE_LEVEL;
         sstrobe_q <= IDLE_LEVEL;
         done_q    <= 1'b0;
      end else begin
         state     <= state_nxt;
         shreg     <= shreg_nxt;
         bitcnt    <= bitcnt_nxt;
         sdata_q   <= sdata_nxt;
         sstrobe_q <= sstrobe_nxt;
         done_q    <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)    state_nxt = SETUP;
         SETUP:   if (phase_end) state_nxt = HOLD;
         HOLD:    if (phase_end) state_nxt = last_bit ? IDLE : SETUP;
         default: state_nxt = IDLE;
      endcase
   end

   // sdata only moves on the strobe-falling edge or at frame start, never on the rise.
   always_comb begin
      shreg_nxt   = shreg;
      bitcnt_nxt  = bitcnt;
      sdata_nxt   = sdata_q;
      sstrobe_nxt = sstrobe_q;
      done_nxt    = 1'b0;
      case (state)
         IDLE: begin
            sstrobe_nxt = IDLE_LEVEL;
            sdata_nxt   = IDLE_LEVEL;
            if (accept) begin
               shreg_nxt  = load_word;
               bitcnt_nxt = '0;
               sdata_nxt  = bus.in_data[0];
            end
         end
         SETUP: begin
            if (phase_end) sstrobe_nxt = 1'b1;
         end
         HOLD: begin
            if (phase_end) begin
               sstrobe_nxt = 1'b0;
               if (last_bit) begin
                  sdata_nxt = IDLE_LEVEL;
                  done_nxt  = 1'b1;
               end else begin
                  bitcnt_nxt = bitcnt + BW'(1);
                  shreg_nxt  = shreg >> 1;
                  sdata_nxt  = shreg_nxt[0];
               end
            end
         end
         default: begin
            sstrobe_nxt = IDLE_LEVEL;
            sdata_nxt   = IDLE_LEVEL;
         end
      endcase
   end

   assign bus.sdata   = sdata_q;
   assign bus.sstrobe = sstrobe_q;
   assign bus.done    = done_q;
   assign bus.busy    = (state != IDLE);
endmodule
